// File: rtl/dst_tnew_pipe.sv
// Destination / Tnew tracker for the E..W pipeline stages.
// Each stage holds the destination register an in-flight instruction will
// write, plus the cycles remaining until that result exists. From these the
// block derives the D-stage stall and the per-operand forward selects.
module dst_tnew_pipe #(
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int STAGES = 3,
  parameter int FW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        d_dst,
  input  logic [TW-1:0]        d_tnew,
  input  logic [1:0]           d_kind,
  input  logic [AW-1:0]        d_rs,
  input  logic [AW-1:0]        d_rt,
  input  logic [TW-1:0]        d_tuse_rs,
  input  logic [TW-1:0]        d_tuse_rt,
  input  logic                 e_cond,
  input  logic                 flush_e,
  output logic                 stall,
  output logic [FW-1:0]        fwd_rs,
  output logic [FW-1:0]        fwd_rt,
  output logic [STAGES*AW-1:0] stage_dst,
  output logic [STAGES*TW-1:0] stage_tnew
);

  localparam logic [1:0] KIND_UNCOND = 2'd1;
  localparam logic [1:0] KIND_COND   = 2'd2;

  logic [AW-1:0] dst_q  [STAGES];
  logic [AW-1:0] dst_d  [STAGES];
  logic [TW-1:0] tnew_q [STAGES];
  logic [TW-1:0] tnew_d [STAGES];
  logic [1:0]    kind0_q;
  logic [1:0]    kind0_d;

  logic          rs_hit, rt_hit;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic [FW-1:0] rs_sel, rt_sel;

  // Youngest-match search per source operand; scanning oldest to youngest so
  // the last hit written is the lowest stage index.
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = '0;
    rs_sel  = '0;
    rt_hit  = 1'b0;
    rt_tnew = '0;
    rt_sel  = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (d_rs != '0 && dst_q[s] == d_rs) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[s];
        rs_sel  = FW'(s + 1);
      end
      if (d_rt != '0 && dst_q[s] == d_rt) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[s];
        rt_sel  = FW'(s + 1);
      end
    end
  end

  // Stall when the producer is not ready in time; forward only from a ready
  // youngest match (an unready youngest match blocks older stages).
  always_comb begin
    stall  = (rs_hit && (rs_tnew > d_tuse_rs)) || (rt_hit && (rt_tnew > d_tuse_rt));
    fwd_rs = (rs_hit && rs_tnew == '0) ? rs_sel : '0;
    fwd_rt = (rt_hit && rt_tnew == '0) ? rt_sel : '0;
  end

  // Next-state: E entry (with bubbles), conditional nulling at E->M, shift
  // beyond M, saturating Tnew countdown on every transfer.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      dst_d[s]  = dst_q[s];
      tnew_d[s] = tnew_q[s];
    end
    kind0_d = kind0_q;

    if (stall || flush_e || (d_kind != KIND_UNCOND && d_kind != KIND_COND)) begin
      dst_d[0]  = '0;
      tnew_d[0] = '0;
      kind0_d   = '0;
    end else begin
      dst_d[0]  = d_dst;
      tnew_d[0] = d_tnew;
      kind0_d   = d_kind;
    end

    dst_d[1]  = (kind0_q == KIND_COND && !e_cond) ? '0 : dst_q[0];
    tnew_d[1] = (tnew_q[0] == '0) ? '0 : tnew_q[0] - TW'(1);

    for (int s = 1; s < STAGES - 1; s++) begin
      dst_d[s+1]  = dst_q[s];
      tnew_d[s+1] = (tnew_q[s] == '0) ? '0 : tnew_q[s] - TW'(1);
    end
  end

  // Stage registers; reset empties every stage at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        dst_q[s]  <= '0;
        tnew_q[s] <= '0;
      end
      kind0_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        dst_q[s]  <= dst_d[s];
        tnew_q[s] <= tnew_d[s];
      end
      kind0_q <= kind0_d;
    end
  end

  // Pack per-stage state onto the flat outputs, stage 0 in the LSBs.
  always_comb begin
    stage_dst  = '0;
    stage_tnew = '0;
    for (int s = 0; s < STAGES; s++) begin
      stage_dst[s*AW +: AW]  = dst_q[s];
      stage_tnew[s*TW +: TW] = tnew_q[s];
    end
  end

endmodule

// File: tb/tb_dst_tnew_pipe.sv
// Directed bench for dst_tnew_pipe with a queue of pending expectations.
module tb_dst_tnew_pipe;

  localparam int AW = 5;
  localparam int TW = 2;
  localparam int STAGES = 3;
  localparam int FW = 2;

  localparam int S_STALL = 0;
  localparam int S_FRS   = 1;
  localparam int S_FRT   = 2;
  localparam int S_DST   = 3;
  localparam int S_TNEW  = 6;

  logic                 clk;
  logic                 reset;
  logic [AW-1:0]        d_dst;
  logic [TW-1:0]        d_tnew;
  logic [1:0]           d_kind;
  logic [AW-1:0]        d_rs;
  logic [AW-1:0]        d_rt;
  logic [TW-1:0]        d_tuse_rs;
  logic [TW-1:0]        d_tuse_rt;
  logic                 e_cond;
  logic                 flush_e;
  logic                 stall;
  logic [FW-1:0]        fwd_rs;
  logic [FW-1:0]        fwd_rt;
  logic [STAGES*AW-1:0] stage_dst;
  logic [STAGES*TW-1:0] stage_tnew;

  dst_tnew_pipe #(.AW(AW), .TW(TW), .STAGES(STAGES), .FW(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_kind     (d_kind),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .e_cond     (e_cond),
    .flush_e    (flush_e),
    .stall      (stall),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .stage_dst  (stage_dst),
    .stage_tnew (stage_tnew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int observe(int sel);
    int r;
    r = -1;
    if (sel == S_STALL) r = int'(stall);
    else if (sel == S_FRS) r = int'(fwd_rs);
    else if (sel == S_FRT) r = int'(fwd_rt);
    else if (sel >= S_DST && sel < S_DST + STAGES) r = int'(stage_dst[(sel-S_DST)*AW +: AW]);
    else if (sel >= S_TNEW && sel < S_TNEW + STAGES) r = int'(stage_tnew[(sel-S_TNEW)*TW +: TW]);
    return r;
  endfunction

  task automatic push_exp(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic idle();
    d_dst = '0; d_tnew = '0; d_kind = 2'd0;
    d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0;
    e_cond = 1'b0; flush_e = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int kind, input int dst, input int tnew);
    d_kind = 2'(kind);
    d_dst  = AW'(dst);
    d_tnew = TW'(tnew);
  endtask

  task automatic empty_pipe();
    idle();
    repeat (STAGES) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("rst_stall", S_STALL, 0);
    push_exp("rst_fwd_rs", S_FRS, 0);
    push_exp("rst_fwd_rt", S_FRT, 0);
    for (int s = 0; s < STAGES; s++) begin
      push_exp($sformatf("rst_dst%0d", s), S_DST + s, 0);
      push_exp($sformatf("rst_tnew%0d", s), S_TNEW + s, 0);
    end
    drain();
    @(negedge clk);
    reset = 1'b1;

    // Live entry dst=8 in M, then asynchronous reset mid-cycle.
    tick();
    issue(1, 8, 3);
    tick();
    idle();
    tick();
    d_rs = 5'd8;
    #1;
    push_exp("pre_rst_stall", S_STALL, 1);
    push_exp("pre_rst_dst_m", S_DST + 1, 8);
    push_exp("pre_rst_tnew_m", S_TNEW + 1, 2);
    drain();
    @(negedge clk);
    reset = 1'b0;
    #1;
    push_exp("mid_rst_stall", S_STALL, 0);
    push_exp("mid_rst_fwd_rs", S_FRS, 0);
    push_exp("mid_rst_dst_m", S_DST + 1, 0);
    push_exp("mid_rst_tnew_m", S_TNEW + 1, 0);
    drain();
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Load-use: two stall cycles then forward from W.
    tick();
    issue(1, 5, 2);
    tick();
    idle();
    d_rs = 5'd5;
    #1;
    push_exp("lu_stall_c1", S_STALL, 1);
    push_exp("lu_fwd_c1", S_FRS, 0);
    push_exp("lu_dst_e", S_DST, 5);
    push_exp("lu_tnew_e", S_TNEW, 2);
    drain();
    tick();
    push_exp("lu_stall_c2", S_STALL, 1);
    push_exp("lu_bubble_e", S_DST, 0);
    push_exp("lu_dst_m", S_DST + 1, 5);
    push_exp("lu_tnew_m", S_TNEW + 1, 1);
    drain();
    tick();
    push_exp("lu_stall_c3", S_STALL, 0);
    push_exp("lu_fwd_w", S_FRS, 3);
    push_exp("lu_dst_w", S_DST + 2, 5);
    push_exp("lu_tnew_w", S_TNEW + 2, 0);
    push_exp("lu_bubble2_e", S_DST, 0);
    drain();

    // ALU back-to-back: no stall, forward from M next cycle.
    empty_pipe();
    issue(1, 9, 1);
    tick();
    idle();
    d_rt = 5'd9;
    d_tuse_rt = 2'd1;
    #1;
    push_exp("alu_stall", S_STALL, 0);
    push_exp("alu_fwd_rt_e", S_FRT, 0);
    push_exp("alu_tnew_e", S_TNEW, 1);
    drain();
    tick();
    push_exp("alu_fwd_rt_m", S_FRT, 2);
    push_exp("alu_stall_m", S_STALL, 0);
    push_exp("alu_tnew_m", S_TNEW + 1, 0);
    drain();

    // Conditional write, condition false: nulled at E->M.
    empty_pipe();
    issue(2, 12, 1);
    tick();
    idle();
    e_cond = 1'b0;
    #1;
    push_exp("cond0_dst_e", S_DST, 12);
    drain();
    tick();
    d_rs = 5'd12;
    #1;
    push_exp("cond0_dst_m", S_DST + 1, 0);
    push_exp("cond0_fwd_rs", S_FRS, 0);
    push_exp("cond0_stall", S_STALL, 0);
    drain();

    // Conditional write, condition true: kept.
    empty_pipe();
    issue(2, 12, 1);
    tick();
    idle();
    e_cond = 1'b1;
    tick();
    e_cond = 1'b0;
    d_rs = 5'd12;
    #1;
    push_exp("cond1_dst_m", S_DST + 1, 12);
    push_exp("cond1_tnew_m", S_TNEW + 1, 0);
    push_exp("cond1_fwd_rs", S_FRS, 2);
    drain();

    // Reserved kind behaves like no write.
    empty_pipe();
    issue(3, 13, 1);
    tick();
    idle();
    #1;
    push_exp("kind3_dst_e", S_DST, 0);
    drain();

    // Youngest match wins even when an older stage is ready.
    empty_pipe();
    issue(1, 4, 1);
    tick();
    tick();
    idle();
    d_rs = 5'd4;
    d_tuse_rs = 2'd1;
    #1;
    push_exp("young_stall", S_STALL, 0);
    push_exp("young_fwd_rs", S_FRS, 0);
    push_exp("young_dst_e", S_DST, 4);
    push_exp("young_dst_m", S_DST + 1, 4);
    push_exp("young_tnew_m", S_TNEW + 1, 0);
    drain();

    // Register zero is never a hazard or forward source.
    empty_pipe();
    issue(1, 0, 2);
    tick();
    idle();
    #1;
    push_exp("zero_stall", S_STALL, 0);
    push_exp("zero_fwd_rs", S_FRS, 0);
    push_exp("zero_fwd_rt", S_FRT, 0);
    drain();

    // Flush and stall together: one bubble, then normal entry resumes.
    empty_pipe();
    issue(1, 7, 3);
    tick();
    issue(1, 10, 1);
    d_rs = 5'd7;
    flush_e = 1'b1;
    #1;
    push_exp("fs_stall", S_STALL, 1);
    drain();
    tick();
    idle();
    issue(1, 10, 1);
    #1;
    push_exp("fs_bubble_dst", S_DST, 0);
    push_exp("fs_bubble_tnew", S_TNEW, 0);
    push_exp("fs_dst_m", S_DST + 1, 7);
    push_exp("fs_tnew_m", S_TNEW + 1, 2);
    push_exp("fs_no_stall", S_STALL, 0);
    drain();
    tick();
    idle();
    push_exp("fs_next_dst_e", S_DST, 10);
    push_exp("fs_next_tnew_e", S_TNEW, 1);
    drain();
    tick();
    tick();
    push_exp("sat_dst_w", S_DST + 2, 10);
    push_exp("sat_tnew_w", S_TNEW + 2, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
